spi_sipo_multi: RTL and testbench

- Parametrised multi-channel SPI receive deserialiser.
- Shifts NUM_CHANNELS serial lines in lockstep on a sample strobe.
- Counts bits per word, selects MSB-first or LSB-first order, and frames words on chip-select.
- Hands completed words to the consumer through a valid/ready holding register with overrun detection.
- Sits between the SPI clock/CS conditioning logic and the ADC sample FIFO.

---
 rtl/spi_sipo_multi.sv | 135 +++++++++++++
 tb/tb_spi_sipo_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sipo_multi.sv
// Multi-channel SPI receive deserialiser: lockstep shift, word framing on
// chip-select, and a valid/ready holding register with sticky overrun.
module spi_sipo_multi #(
    parameter int NUM_BITS     = 12,
    parameter int NUM_CHANNELS = 1,
    parameter bit LSB_FIRST    = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CHANNELS-1:0]          dataIn,
    input  logic                             enable,
    input  logic                             frameActive,
    input  logic                             dataReady,
    input  logic                             clearStatus,
    output logic [NUM_CHANNELS*NUM_BITS-1:0] dataOut,
    output logic                             dataValid,
    output logic                             overrun,
    output logic                             frameAbort,
    output logic                             busy
);

    localparam int W  = NUM_CHANNELS * NUM_BITS;
    localparam int CW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sr_q, sr_d;
    logic [W-1:0]    dout_q, dout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic            abort_q, abort_d;

    logic [W-1:0]        sr_shift;
    logic [NUM_BITS-1:0] word;
    logic                accept;
    logic                last_bit;
    logic                complete;
    logic                abort;
    logic                consume;

    assign accept   = enable & frameActive;
    assign last_bit = (cnt_q == LAST);
    assign complete = accept & last_bit;
    assign abort    = (state_q == SHIFT) & ~frameActive;
    assign consume  = valid_q & dataReady;

    // Every channel shifts in the same direction on the same strobe.
    always_comb begin
        sr_shift = '0;
        word     = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            word = sr_q[c*NUM_BITS +: NUM_BITS];
            if (LSB_FIRST) begin
                sr_shift[c*NUM_BITS +: NUM_BITS] =
                    {dataIn[c], word[NUM_BITS-1:1]};
            end else begin
                sr_shift[c*NUM_BITS +: NUM_BITS] =
                    {word[NUM_BITS-2:0], dataIn[c]};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        abort_d = 1'b0;

        if (accept) begin
            sr_d = sr_shift;
            if (last_bit) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = SHIFT;
            end
        end else if (abort) begin
            sr_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
            abort_d = 1'b1;
        end

        // A completing word always lands, even over an unconsumed one.
        if (complete) begin
            dout_d  = sr_shift;
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end

        if (complete && valid_q && !dataReady) begin
            ovr_d = 1'b1;
        end else if (clearStatus) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            abort_q <= abort_d;
        end
    end

    assign dataOut    = dout_q;
    assign dataValid  = valid_q;
    assign overrun    = ovr_q;
    assign frameAbort = abort_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_sipo_multi.sv
// Bench for spi_sipo_multi: default 12-bit MSB-first instance plus a
// two-channel LSB-first instance, scoreboard of expected words.
module tb_spi_sipo_multi;

    logic clk = 1'b0;
    logic rst;

    logic        d0_in, en0, fa0, rdy0, clr0;
    logic [11:0] d0_out;
    logic        v0, ov0, ab0, bz0;

    logic [1:0]  d1_in;
    logic        en1, fa1, rdy1, clr1;
    logic [23:0] d1_out;
    logic        v1, ov1, ab1, bz1;

    int checks   = 0;
    int failures = 0;
    int mon_seen = 0;
    bit mon_en   = 1'b0;
    logic [23:0] mon_exp;
    logic [23:0] sb[$];

    typedef struct {
        logic [11:0] send;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    spi_sipo_multi dut0 (
        .clk(clk), .reset(rst), .dataIn(d0_in), .enable(en0),
        .frameActive(fa0), .dataReady(rdy0), .clearStatus(clr0),
        .dataOut(d0_out), .dataValid(v0), .overrun(ov0),
        .frameAbort(ab0), .busy(bz0)
    );

    spi_sipo_multi #(.NUM_BITS(12), .NUM_CHANNELS(2), .LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(rst), .dataIn(d1_in), .enable(en1),
        .frameActive(fa1), .dataReady(rdy1), .clearStatus(clr1),
        .dataOut(d1_out), .dataValid(v1), .overrun(ov1),
        .frameAbort(ab1), .busy(bz1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send bits w[hi] down to w[lo] on consecutive strobes, MSB first.
    task automatic bits0(input logic [11:0] w, input int hi, input int lo,
                         input bit cb);
        for (int i = hi; i >= lo; i--) begin
            d0_in = w[i];
            en0   = 1'b1;
            fa0   = 1'b1;
            tick();
            if (cb) chk("busy", {31'd0, bz0}, {31'd0, i != 0});
        end
        en0   = 1'b0;
        d0_in = 1'b0;
    endtask

    task automatic consume0();
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        chk("consume_valid", {31'd0, v0}, 32'd0);
    endtask

    task automatic send_chk0(input logic [11:0] w, input string name);
        sb.push_back({12'd0, w});
        bits0(w, 11, 0, 1'b0);
        chk(name, {20'd0, d0_out}, sb.pop_front());
        chk("valid", {31'd0, v0}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (mon_en && v0 && rdy0) begin
            if (sb.size() == 0) begin
                chk("b2b_unexpected", {20'd0, d0_out}, 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                chk("b2b_word", {20'd0, d0_out}, {8'd0, mon_exp});
            end
            mon_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] a;
        logic [11:0] b;

        tbl[0] = '{12'hA5C, 12'hA5C};
        tbl[1] = '{12'h3C3, 12'h3C3};
        tbl[2] = '{12'h800, 12'h800};
        tbl[3] = '{12'h001, 12'h001};
        tbl[4] = '{12'h7E1, 12'h7E1};

        rst = 1'b1;
        {d0_in, en0, fa0, rdy0, clr0} = '0;
        {d1_in, en1, fa1, rdy1, clr1} = '0;
        repeat (2) tick();
        chk("rst_out0", {20'd0, d0_out}, 32'd0);
        chk("rst_flags0", {28'd0, v0, ov0, ab0, bz0}, 32'd0);
        chk("rst_out1", {8'd0, d1_out}, 32'd0);
        chk("rst_flags1", {28'd0, v1, ov1, ab1, bz1}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            sb.push_back({12'd0, tbl[i].exp});
            bits0(tbl[i].send, 11, 1, 1'b1);
            chk("valid_early", {31'd0, v0}, 32'd0);
            bits0(tbl[i].send, 0, 0, 1'b1);
            chk("tbl_valid", {31'd0, v0}, 32'd1);
            chk("tbl_word", {20'd0, d0_out}, sb.pop_front());
            chk("tbl_ovr", {31'd0, ov0}, 32'd0);
            consume0();
        end

        a = 12'h123;
        b = 12'hFED;
        sb.push_back(24'hFED123);
        for (int i = 0; i < 12; i++) begin
            d1_in = {b[i], a[i]};
            en1   = 1'b1;
            fa1   = 1'b1;
            tick();
        end
        en1 = 1'b0;
        chk("lsb_valid", {31'd0, v1}, 32'd1);
        chk("lsb_word", {8'd0, d1_out}, {8'd0, sb.pop_front()});

        mon_en   = 1'b1;
        mon_seen = 0;
        rdy0     = 1'b1;
        sb.push_back(24'h001);
        sb.push_back(24'hFFF);
        bits0(12'h001, 11, 0, 1'b1);
        bits0(12'hFFF, 11, 0, 1'b1);
        for (int k = 0; k < 5 && sb.size() != 0; k++) tick();
        chk("b2b_drain", sb.size(), 32'd0);
        chk("b2b_count", mon_seen, 32'd2);
        chk("b2b_ovr", {31'd0, ov0}, 32'd0);
        mon_en = 1'b0;
        rdy0   = 1'b0;
        sb.delete();
        tick();

        sb.push_back(24'h0F0);
        sb.push_back(24'h70E);
        bits0(12'h0F0, 11, 0, 1'b0);
        bits0(12'h70E, 11, 0, 1'b0);
        void'(sb.pop_front());
        chk("ovr_word", {20'd0, d0_out}, sb.pop_front());
        chk("ovr_set", {31'd0, ov0}, 32'd1);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        chk("ovr_clear", {31'd0, ov0}, 32'd0);
        chk("ovr_clear_valid", {31'd0, v0}, 32'd1);

        bits0(12'h9A9, 11, 1, 1'b0);
        clr0 = 1'b1;
        bits0(12'h9A9, 0, 0, 1'b0);
        clr0 = 1'b0;
        chk("ovr_set_wins", {31'd0, ov0}, 32'd1);
        chk("ovr_set_word", {20'd0, d0_out}, 32'h9A9);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        consume0();

        send_chk0(12'h4B2, "hold_word");
        bits0(12'hC0D, 11, 1, 1'b0);
        rdy0 = 1'b1;
        bits0(12'hC0D, 0, 0, 1'b0);
        rdy0 = 1'b0;
        chk("coin_valid", {31'd0, v0}, 32'd1);
        chk("coin_word", {20'd0, d0_out}, 32'hC0D);
        chk("coin_ovr", {31'd0, ov0}, 32'd0);
        consume0();

        send_chk0(12'h555, "pre_abort_word");
        bits0(12'hABC, 11, 7, 1'b0);
        chk("abort_busy_pre", {31'd0, bz0}, 32'd1);
        fa0 = 1'b0;
        tick();
        chk("abort_pulse", {31'd0, ab0}, 32'd1);
        chk("abort_busy", {31'd0, bz0}, 32'd0);
        chk("abort_valid", {31'd0, v0}, 32'd1);
        chk("abort_word", {20'd0, d0_out}, 32'h555);
        tick();
        chk("abort_one_cycle", {31'd0, ab0}, 32'd0);
        en0 = 1'b1;
        tick();
        en0 = 1'b0;
        chk("idle_no_pulse", {31'd0, ab0}, 32'd0);
        chk("idle_ignore_en", {31'd0, bz0}, 32'd0);
        consume0();
        sb.push_back(24'h3C3);
        bits0(12'h3C3, 11, 0, 1'b1);
        chk("post_abort_word", {20'd0, d0_out}, sb.pop_front());
        consume0();

        bits0(12'h111, 11, 0, 1'b0);
        bits0(12'h222, 11, 0, 1'b0);
        chk("pre_rst_ovr", {31'd0, ov0}, 32'd1);
        bits0(12'h6A6, 11, 5, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out", {20'd0, d0_out}, 32'd0);
        chk("async_rst_flags", {28'd0, v0, ov0, ab0, bz0}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_abort", {31'd0, ab0}, 32'd0);
        sb.push_back(24'h800);
        bits0(12'h800, 11, 0, 1'b1);
        chk("post_rst_word", {20'd0, d0_out}, sb.pop_front());
        chk("post_rst_valid", {31'd0, v0}, 32'd1);
        consume0();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
